// File: rtl/pwm_note_sequencer.sv
// pwm_note_sequencer: plays a programmable table of {divider, duration} notes
// on the pwm_sine tone generator. A tempo prescaler produces ticks; each note
// sounds for its duration in ticks, followed by GAP_TK silent ticks.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/addr/div/dur      single-cycle table write port (accepted in any state)
//   tick_period              one tick every tick_period+1 cycles (sampled live)
//   start, stop, loop        playback control
//   divider, note_on         registered drive to pwm_sine
//   busy, step_idx, done     registered status; done pulses on natural end
module pwm_note_sequencer #(
  parameter int unsigned DIV_W  = 12,
  parameter int unsigned DUR_W  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned TICK_W = 16,
  parameter int unsigned GAP_TK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic [TICK_W-1:0] tick_period,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [DIV_W-1:0]  divider,
  output logic              note_on,
  output logic              busy,
  output logic [ADDR_W-1:0] step_idx,
  output logic              done
);

  localparam int unsigned STEPS = 2 ** ADDR_W;
  localparam int unsigned GAP_W = (GAP_TK > 1) ? $clog2(GAP_TK + 1) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  logic [DIV_W-1:0] tbl_div [STEPS];
  logic [DUR_W-1:0] tbl_dur [STEPS];

  state_t            state, state_n;
  logic [TICK_W-1:0] pre_cnt, pre_n;
  logic [DUR_W-1:0]  remain, remain_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [DIV_W-1:0]  div_n;
  logic              non_n, busy_n, done_n;
  logic [ADDR_W-1:0] idx_n;

  logic              tick_c;
  logic              adv, do_load, do_end, do_play;
  logic [ADDR_W-1:0] ld_idx, pl_idx;

  // Note table; reads are combinational so a same-cycle write loads old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STEPS); i++) begin
        tbl_div[i] <= '0;
        tbl_dur[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_div[cfg_addr] <= cfg_div;
      tbl_dur[cfg_addr] <= cfg_dur;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      remain   <= '0;
      gap_cnt  <= '0;
      divider  <= '0;
      note_on  <= 1'b0;
      busy     <= 1'b0;
      step_idx <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pre_cnt  <= pre_n;
      remain   <= remain_n;
      gap_cnt  <= gap_n;
      divider  <= div_n;
      note_on  <= non_n;
      busy     <= busy_n;
      step_idx <= idx_n;
      done     <= done_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n  = state;
    pre_n    = pre_cnt;
    remain_n = remain;
    gap_n    = gap_cnt;
    div_n    = divider;
    non_n    = note_on;
    idx_n    = step_idx;
    done_n   = 1'b0;
    adv      = 1'b0;
    do_load  = 1'b0;
    do_end   = 1'b0;
    do_play  = 1'b0;
    ld_idx   = '0;
    pl_idx   = '0;
    tick_c   = (pre_cnt == tick_period);

    case (state)
      IDLE: begin
        pre_n = '0;
        if (start && !stop) begin
          do_load = 1'b1;
          ld_idx  = '0;
        end
      end
      PLAY: begin
        pre_n = tick_c ? '0 : TICK_W'(pre_cnt + TICK_W'(1));
        if (tick_c) begin
          if (remain == DUR_W'(1)) begin
            if (GAP_TK != 0) begin
              non_n   = 1'b0;
              gap_n   = GAP_W'(GAP_TK);
              state_n = GAP;
            end else begin
              adv = 1'b1;
            end
          end else begin
            remain_n = DUR_W'(remain - DUR_W'(1));
          end
        end
      end
      GAP: begin
        pre_n = tick_c ? '0 : TICK_W'(pre_cnt + TICK_W'(1));
        if (tick_c) begin
          if (gap_cnt == GAP_W'(1)) adv = 1'b1;
          else gap_n = GAP_W'(gap_cnt - GAP_W'(1));
        end
      end
      default: state_n = IDLE;
    endcase

    // Advance to the next step; the last table slot always ends the pass
    if (adv) begin
      if (step_idx == ADDR_W'(STEPS - 1)) begin
        do_end = 1'b1;
      end else begin
        do_load = 1'b1;
        ld_idx  = ADDR_W'(step_idx + ADDR_W'(1));
      end
    end

    // A zero duration marks the end of the sequence
    if (do_load) begin
      if (tbl_dur[ld_idx] == '0) begin
        do_end = 1'b1;
      end else begin
        do_play = 1'b1;
        pl_idx  = ld_idx;
      end
    end

    if (do_end) begin
      if (loop && (tbl_dur[0] != '0)) begin
        do_play = 1'b1;
        pl_idx  = '0;
      end else begin
        state_n = IDLE;
        non_n   = 1'b0;
        idx_n   = '0;
        done_n  = 1'b1;
      end
    end

    if (do_play) begin
      state_n  = PLAY;
      div_n    = tbl_div[pl_idx];
      remain_n = tbl_dur[pl_idx];
      non_n    = 1'b1;
      idx_n    = pl_idx;
    end

    // Abort overrides everything and never pulses done
    if (stop && (state != IDLE)) begin
      state_n = IDLE;
      non_n   = 1'b0;
      idx_n   = '0;
      done_n  = 1'b0;
      pre_n   = '0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_pwm_note_sequencer.sv
module tb_pwm_note_sequencer;

  localparam int unsigned GAP = 1;

  logic        clk = 1'b0;
  logic        rst, cfg_we, start, stop, loop;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_div;
  logic [7:0]  cfg_dur;
  logic [15:0] tick_period;
  logic [11:0] divider;
  logic        note_on, busy, done;
  logic [3:0]  step_idx;

  pwm_note_sequencer #(.DIV_W(12), .DUR_W(8), .ADDR_W(4), .TICK_W(16), .GAP_TK(GAP)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_div(cfg_div),
    .cfg_dur(cfg_dur), .tick_period(tick_period), .start(start), .stop(stop), .loop(loop),
    .divider(divider), .note_on(note_on), .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] div;
    logic        non;
    logic        busy;
    logic [3:0]  idx;
    logic        done;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] m_div [16];
  logic [7:0]  m_dur [16];
  logic [11:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_div[i] = '0;
      m_dur[i] = '0;
    end
    m_last = '0;
  endtask

  // Table write; entered and left on a falling edge
  task automatic wr(input int a, input logic [11:0] d, input logic [7:0] u);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_div = d; cfg_dur = u;
    m_div[a] = d; m_dur[a] = u;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Expected per-cycle trace of one pass: u*T cycles sounding, GAP*T silent
  task automatic gen_pass(input bit fin);
    exp_t e;
    int   t;
    t = int'(tick_period) + 1;
    for (int i = 0; i < 16; i++) begin
      if (m_dur[i] == 0) break;
      e.div = m_div[i]; e.busy = 1'b1; e.idx = 4'(i); e.done = 1'b0;
      e.non = 1'b1;
      for (int c = 0; c < int'(m_dur[i]) * t; c++) q.push_back(e);
      e.non = 1'b0;
      for (int c = 0; c < int'(GAP) * t; c++) q.push_back(e);
      m_last = m_div[i];
    end
    if (fin) begin
      e.div = m_last; e.non = 1'b0; e.busy = 1'b0; e.idx = '0; e.done = 1'b1;
      q.push_back(e);
      e.done = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic cmp(input string tag, input int k, input exp_t e);
    chk($sformatf("%s[%0d].div", tag, k), 32'(divider), 32'(e.div));
    chk($sformatf("%s[%0d].note_on", tag, k), 32'(note_on), 32'(e.non));
    chk($sformatf("%s[%0d].busy", tag, k), 32'(busy), 32'(e.busy));
    chk($sformatf("%s[%0d].done", tag, k), 32'(done), 32'(e.done));
    if (e.busy) chk($sformatf("%s[%0d].step_idx", tag, k), 32'(step_idx), 32'(e.idx));
  endtask

  // Pulse start, compare the expected trace, optional table write at cycle wr_at
  task automatic run(input string tag, input int limit, input int wr_at,
                     input logic [11:0] wr_div, input bit do_stop);
    int k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < q.size() && k < limit) begin
      if (k == wr_at) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_div = wr_div; cfg_dur = m_dur[0];
      end else begin
        cfg_we = 1'b0;
      end
      cmp(tag, k, q[k]);
      m_last = q[k].div;
      @(negedge clk);
      k++;
    end
    cfg_we = 1'b0;
    if (k < q.size()) m_last = q[k].div;
    if (do_stop) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk({tag, ".stop.busy"}, 32'(busy), 32'd0);
      chk({tag, ".stop.note_on"}, 32'(note_on), 32'd0);
      chk({tag, ".stop.step_idx"}, 32'(step_idx), 32'd0);
      chk({tag, ".stop.done"}, 32'(done), 32'd0);
    end
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".div"}, 32'(divider), 32'd0);
    chk({tag, ".note_on"}, 32'(note_on), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".step_idx"}, 32'(step_idx), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int p1, n;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_div = '0; cfg_dur = '0;
    tick_period = 16'd4; start = 1'b0; stop = 1'b0; loop = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Empty table: start ends at once
    gen_pass(1'b1);
    run("empty", 1000, -1, '0, 1'b0);

    // Two-note sequence, one-shot
    wr(0, 12'h100, 8'd3);
    wr(1, 12'h080, 8'd2);
    wr(2, 12'h5A5, 8'd0);
    gen_pass(1'b1);
    run("two_note", 1000, -1, '0, 1'b0);

    // Loop restarts at step 0 without done, then stop
    loop = 1'b1;
    gen_pass(1'b0);
    gen_pass(1'b0);
    run("loop", 40, -1, '0, 1'b1);

    // Rewriting step 0 while it plays only shows on the next pass
    gen_pass(1'b0);
    m_div[0] = 12'h3FF;
    gen_pass(1'b0);
    run("live_wr", 50, 3, 12'h3FF, 1'b1);

    // All 16 steps, one tick each, tick every cycle
    loop = 1'b0;
    tick_period = 16'd0;
    for (int a = 0; a < 16; a++) wr(a, 12'($urandom), 8'd1);
    gen_pass(1'b1);
    run("wrap16", 1000, -1, '0, 1'b0);

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop.busy", 32'(busy), 32'd0);
    chk("startstop.note_on", 32'(note_on), 32'd0);
    chk("startstop.done", 32'(done), 32'd0);

    // Reset during playback
    tick_period = 16'd2;
    gen_pass(1'b1);
    run("pre_rst", 5, -1, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    rst = 1'b0;
    model_clear();
    @(negedge clk);

    // Randomized tables, tempos and loop mode
    for (int r = 0; r < 8; r++) begin
      tick_period = 16'($urandom_range(0, 3));
      loop = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 16));
      for (int a = 0; a < 16; a++)
        wr(a, 12'($urandom), (a == n) ? 8'd0 : 8'($urandom_range(1, 3)));
      if (loop) begin
        gen_pass(1'b0);
        p1 = q.size();
        gen_pass(1'b0);
        run($sformatf("rnd%0d", r), p1 + 7, -1, '0, 1'b1);
      end else begin
        gen_pass(1'b1);
        run($sformatf("rnd%0d", r), 100000, -1, '0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
